sum_tree_sat: RTL and testbench
===============================

SUM_TREE_SAT -- requirements
Module: sum_tree_sat

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, meaning number of MAC partial sums to add (power of two, 2..16).
REQ-002 SHALL have parameter IN_W, default 16, meaning signed width of each input.
REQ-003 SHALL have parameter OUT_W, default 16, meaning signed output width (OUT_W <= IN_W + log2(NUM_IN)).
REQ-004 SHALL have port iClk_12M  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port iRsn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port iEnSample_600k  input  1  sample strobe.
REQ-007 SHALL have port iEnDelay  input  1  delay-line-ready qualifier; a sample is accepted only when both strobes are 1.
REQ-008 SHALL have port iMac  input  NUM_IN*IN_W  packed signed inputs, channel k at bits [k*IN_W +: IN_W].
REQ-009 SHALL have port iClrStat  input  1  synchronous clear of sticky flags and counter.
REQ-010 SHALL have port oFirOut  output  OUT_W  saturated sum, held between updates.
REQ-011 SHALL have port oValid  output  1  one-cycle pulse when oFirOut updates.
REQ-012 SHALL have ports oSatPos / oSatNeg  output  1 each  sticky positive / negative saturation flags.
REQ-013 SHALL have port oSatCnt  output  16  saturation event count (present only with SUM_SATCNT_EN).

Function
REQ-014 SHALL capture iMac into stage-0 registers on every cycle where iEnSample_600k=1 and iEnDelay=1; otherwise stage 0 carries an invalid token.
REQ-015 SHALL add in a registered binary tree of L=log2(NUM_IN) levels, each level widening by one bit, final width IN_W+L; no internal wrap.
REQ-016 SHALL carry a valid bit alongside every pipeline stage; pipeline advances every clock, no stall.
REQ-017 SHALL register the saturated result one cycle after the last tree level; total latency from accepting edge to oValid = L+2 cycles (4 for NUM_IN=4).
REQ-018 SHALL accept back-to-back samples on consecutive cycles, producing consecutive oValid pulses.
REQ-019 SHALL clamp: sum > 2^(OUT_W-1)-1 -> 2^(OUT_W-1)-1; sum < -2^(OUT_W-1) -> -2^(OUT_W-1); else sign-truncated sum.
REQ-020 SHALL set oSatPos/oSatNeg on the cycle a valid clamped result is registered; flags remain set until iClrStat.
REQ-021 SHALL let a new saturation event win over a simultaneous iClrStat (flag ends set, counter ends at 1).
REQ-022 SHALL leave oFirOut unchanged and oValid=0 on cycles with no valid token at the output stage.

Reset
REQ-023 SHALL, on iRsn=0, asynchronously clear all data stages, valid bits, oFirOut=0, oValid=0, oSatPos=0, oSatNeg=0, oSatCnt=0.
REQ-024 SHALL discard samples in flight when reset asserts mid-pipeline; no oValid until a new sample is accepted after release.

Configuration
REQ-025 SHALL, with macro SUM_SATCNT_EN defined, provide oSatCnt incrementing by 1 per clamped valid result, saturating at 0xFFFF, cleared by iClrStat.
REQ-026 SHALL, without SUM_SATCNT_EN, omit oSatCnt port and counter logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place clog2 function, default parameter values and saturation-limit constant functions in shared package sum_tree_pkg.
REQ-028 SHALL implement one tree level as sub-module sum_tree_level (parametrised count/width, registered pairwise adds with valid), instantiated L times via generate.

Verification
REQ-029 SHALL cover: NUM_IN=4, iMac={100,200,-50,-250}, both strobes 1 -> oFirOut=0, oValid exactly 4 cycles later, no flags.
REQ-030 SHALL cover: all inputs 0x4000 -> oFirOut=0x7FFF, oSatPos=1; all inputs 0x8000 -> oFirOut=0x8000, oSatNeg=1; oSatCnt=2.
REQ-031 SHALL cover: iEnSample_600k=1, iEnDelay=0 -> no oValid, oFirOut unchanged.
REQ-032 SHALL cover: three back-to-back samples {1,1,1,1},{2,2,2,2},{3,3,3,3} -> oFirOut 4, 8, 12 on three consecutive oValid cycles.
REQ-033 SHALL cover: iRsn pulsed low 2 cycles after accepting a sample -> all outputs 0, no oValid for that sample.
REQ-034 SHALL cover: iClrStat coincident with a clamped result -> oSatPos stays 1, oSatCnt=1; NUM_IN=8, IN_W=12 regression of REQ-029/030.

Source files
------------

// File: rtl/sum_tree_pkg.sv
// Shared constants and helpers for the saturating adder tree (sum_tree_sat).
package sum_tree_pkg;

  localparam int unsigned DEF_NUM_IN = 4;
  localparam int unsigned DEF_IN_W   = 16;
  localparam int unsigned DEF_OUT_W  = 16;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Two's-complement limits of a w-bit signed value, widened to 64 bits
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One registered level of the adder tree: CNT signed W-bit inputs -> CNT/2 sums of W+1 bits.
module sum_tree_level #(
  parameter int unsigned CNT = 2,
  parameter int unsigned W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       src_valid,
  input  logic [CNT*W-1:0]           src_data,
  output logic                       sum_valid,
  output logic [(CNT/2)*(W+1)-1:0]   sum_data
);

  logic [(CNT/2)*(W+1)-1:0] sum_next;

  // Operands are sign-extended by one bit before adding, so the pair sum never wraps
  always_comb begin
    sum_next = '0;
    for (int unsigned k = 0; k < CNT / 2; k++) begin
      sum_next[k*(W+1) +: W+1] = (W+1)'($signed(src_data[(2*k)*W +: W]))
                               + (W+1)'($signed(src_data[(2*k+1)*W +: W]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_valid <= 1'b0;
      sum_data  <= '0;
    end else begin
      sum_valid <= src_valid;
      if (src_valid) sum_data <= sum_next;
    end
  end

endmodule

// File: rtl/sum_tree_sat.sv
// Pipelined signed adder tree with output saturation and sticky clamp flags.
// Define SUM_SATCNT_EN to add the 16-bit saturation event counter port oSatCnt.
module sum_tree_sat
  import sum_tree_pkg::*;
#(
  parameter int unsigned NUM_IN = DEF_NUM_IN,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                    iClk_12M,
  input  logic                    iRsn,
  input  logic                    iEnSample_600k,
  input  logic                    iEnDelay,
  input  logic [NUM_IN*IN_W-1:0]  iMac,
  input  logic                    iClrStat,
  output logic [OUT_W-1:0]        oFirOut,
  output logic                    oValid,
`ifdef SUM_SATCNT_EN
  output logic [15:0]             oSatCnt,
`endif
  output logic                    oSatPos,
  output logic                    oSatNeg
);

  localparam int unsigned L  = clog2(NUM_IN);
  localparam int unsigned SW = IN_W + L;

  localparam logic signed [SW-1:0]    MAX_S = SW'(sat_max(OUT_W));
  localparam logic signed [SW-1:0]    MIN_S = SW'(sat_min(OUT_W));
  localparam logic signed [OUT_W-1:0] MAX_O = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0] MIN_O = OUT_W'(sat_min(OUT_W));

  logic                   accept;
  logic [NUM_IN*IN_W-1:0] s0_data;
  logic                   s0_valid;

  assign accept = iEnSample_600k & iEnDelay;

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= accept;
      if (accept) s0_data <= iMac;
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int unsigned CNT = NUM_IN >> l;
    localparam int unsigned W   = IN_W + l;

    logic [CNT*W-1:0]         src_data;
    logic                     src_valid;
    logic [(CNT/2)*(W+1)-1:0] data;
    logic                     valid;

    if (l == 0) begin : g_src
      assign src_data  = s0_data;
      assign src_valid = s0_valid;
    end else begin : g_src
      assign src_data  = g_lvl[l-1].data;
      assign src_valid = g_lvl[l-1].valid;
    end

    sum_tree_level #(
      .CNT (CNT),
      .W   (W)
    ) u_level (
      .clk       (iClk_12M),
      .rst_n     (iRsn),
      .src_valid (src_valid),
      .src_data  (src_data),
      .sum_valid (valid),
      .sum_data  (data)
    );
  end

  logic signed [SW-1:0]    tree_sum;
  logic                    tree_valid;
  logic                    over_pos;
  logic                    over_neg;
  logic signed [OUT_W-1:0] clamped;

  assign tree_sum   = g_lvl[L-1].data;
  assign tree_valid = g_lvl[L-1].valid;

  always_comb begin
    over_pos = tree_sum > MAX_S;
    over_neg = tree_sum < MIN_S;
    if (over_pos)      clamped = MAX_O;
    else if (over_neg) clamped = MIN_O;
    else               clamped = tree_sum[OUT_W-1:0];
  end

  // Clamp decision is registered first; the output stage then only muxes and updates flags
  logic [OUT_W-1:0] sat_data;
  logic             sat_valid;
  logic             sat_pos_evt;
  logic             sat_neg_evt;

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      sat_data    <= '0;
      sat_valid   <= 1'b0;
      sat_pos_evt <= 1'b0;
      sat_neg_evt <= 1'b0;
    end else begin
      sat_valid   <= tree_valid;
      sat_pos_evt <= tree_valid & over_pos;
      sat_neg_evt <= tree_valid & over_neg;
      if (tree_valid) sat_data <= clamped;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oFirOut <= '0;
      oValid  <= 1'b0;
      oSatPos <= 1'b0;
      oSatNeg <= 1'b0;
    end else begin
      oValid <= sat_valid;
      if (sat_valid) oFirOut <= sat_data;
      // A fresh clamp event takes priority over a coincident clear
      if (sat_pos_evt)   oSatPos <= 1'b1;
      else if (iClrStat) oSatPos <= 1'b0;
      if (sat_neg_evt)   oSatNeg <= 1'b1;
      else if (iClrStat) oSatNeg <= 1'b0;
    end
  end

`ifdef SUM_SATCNT_EN
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oSatCnt <= '0;
    end else if (sat_pos_evt | sat_neg_evt) begin
      if (iClrStat)           oSatCnt <= 16'd1;
      else if (oSatCnt != '1) oSatCnt <= oSatCnt + 16'd1;
    end else if (iClrStat) begin
      oSatCnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sum_tree_sat.sv
// Self-checking bench for sum_tree_sat: default (4x16->16) and an 8x12->12 instance.
module tb_sum_tree_sat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_s = 1'b0;
  logic        en_d = 1'b0;
  logic        clr4 = 1'b0;
  logic        clr8 = 1'b0;
  logic [63:0] mac4 = '0;
  logic [95:0] mac8 = '0;
  logic [15:0] out4;
  logic [11:0] out8;
  logic        v4, v8, sp4, sn4, sp8, sn8;
`ifdef SUM_SATCNT_EN
  logic [15:0] cnt4, cnt8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int ch4 [4];
  int ch8 [8];

  longint m_out4, m_out8;
  bit     m_sp4, m_sn4, m_sp8, m_sn8;
  int     m_cnt4, m_cnt8;

  always #5 clk = ~clk;

  sum_tree_sat dut4 (
    .iClk_12M       (clk),
    .iRsn           (rst_n),
    .iEnSample_600k (en_s),
    .iEnDelay       (en_d),
    .iMac           (mac4),
    .iClrStat       (clr4),
    .oFirOut        (out4),
    .oValid         (v4),
`ifdef SUM_SATCNT_EN
    .oSatCnt        (cnt4),
`endif
    .oSatPos        (sp4),
    .oSatNeg        (sn4)
  );

  sum_tree_sat #(
    .NUM_IN (8),
    .IN_W   (12),
    .OUT_W  (12)
  ) dut8 (
    .iClk_12M       (clk),
    .iRsn           (rst_n),
    .iEnSample_600k (en_s),
    .iEnDelay       (en_d),
    .iMac           (mac8),
    .iClrStat       (clr8),
    .oFirOut        (out8),
    .oValid         (v8),
`ifdef SUM_SATCNT_EN
    .oSatCnt        (cnt8),
`endif
    .oSatPos        (sp8),
    .oSatNeg        (sn8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint s, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // Reference: plain integer sum of the channels, clamped; clear applied before the event
  function automatic void model_accept(input bit with_clr);
    longint s4, s8, c4, c8;
    s4 = 0;
    s8 = 0;
    foreach (ch4[i]) s4 += ch4[i];
    foreach (ch8[i]) s8 += ch8[i];
    if (with_clr) begin
      m_sp4 = 0; m_sn4 = 0; m_cnt4 = 0;
      m_sp8 = 0; m_sn8 = 0; m_cnt8 = 0;
    end
    c4 = clamp(s4, 16);
    c8 = clamp(s8, 12);
    m_out4 = c4;
    m_out8 = c8;
    if (s4 > c4) m_sp4 = 1;
    if (s4 < c4) m_sn4 = 1;
    if (s4 != c4 && m_cnt4 < 65535) m_cnt4++;
    if (s8 > c8) m_sp8 = 1;
    if (s8 < c8) m_sn8 = 1;
    if (s8 != c8 && m_cnt8 < 65535) m_cnt8++;
  endfunction

  task automatic drive_mac();
    for (int i = 0; i < 4; i++) mac4[i*16 +: 16] = 16'(ch4[i]);
    for (int i = 0; i < 8; i++) mac8[i*12 +: 12] = 12'(ch8[i]);
  endtask

  task automatic check_status();
    chk("out4", $signed(out4), m_out4);
    chk("out8", $signed(out8), m_out8);
    chk("satpos4", sp4, m_sp4);
    chk("satneg4", sn4, m_sn4);
    chk("satpos8", sp8, m_sp8);
    chk("satneg8", sn8, m_sn8);
`ifdef SUM_SATCNT_EN
    chk("satcnt4", cnt4, m_cnt4);
    chk("satcnt8", cnt8, m_cnt8);
`endif
  endtask

  // One isolated sample; dut4 answers 4 edges later, dut8 5 edges later
  task automatic run_one(input bit with_clr);
    model_accept(with_clr);
    drive_mac();
    en_s = 1; en_d = 1;
    tick();
    en_s = 0; en_d = 0;
    for (int c = 1; c <= 5; c++) begin
      clr4 = with_clr && (c == 4);
      clr8 = with_clr && (c == 5);
      tick();
      chk("valid4", v4, (c == 4));
      chk("valid8", v8, (c == 5));
      if (c == 4) chk("out4_at_valid", $signed(out4), m_out4);
    end
    clr4 = 0; clr8 = 0;
    check_status();
  endtask

  task automatic fill(input int v4val, input int v8val);
    foreach (ch4[i]) ch4[i] = v4val;
    foreach (ch8[i]) ch8[i] = v8val;
  endtask

  task automatic randomize_channels();
    foreach (ch4[i]) begin
      ch4[i] = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 1) == 1) ch4[i] = ch4[i] / 8;
    end
    foreach (ch8[i]) begin
      ch8[i] = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 1) == 1) ch8[i] = ch8[i] / 8;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int exp4 [9];
    int exp8 [9];

    m_out4 = 0; m_out8 = 0;
    m_sp4 = 0; m_sn4 = 0; m_sp8 = 0; m_sn8 = 0;
    m_cnt4 = 0; m_cnt8 = 0;

    // Reset state
    tick();
    tick();
    chk("rst_valid4", v4, 1'b0);
    chk("rst_valid8", v8, 1'b0);
    check_status();
    rst_n = 1;
    tick();

    // Zero-sum mix, no clamp
    ch4 = '{100, 200, -50, -250};
    ch8 = '{100, 200, -50, -250, 10, -10, 0, 0};
    run_one(0);

    // Positive then negative full-scale clamp
    fill(16'sh4000, 12'sh400);
    run_one(0);
    fill(-32768, -2048);
    run_one(0);

    // Only one strobe high: nothing accepted, output held
    randomize_channels();
    drive_mac();
    en_s = 1; en_d = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 4) begin en_s = 0; en_d = 1; end
      tick();
      chk("qual_valid4", v4, 1'b0);
      chk("qual_valid8", v8, 1'b0);
    end
    en_s = 0; en_d = 0;
    check_status();

    // Three back-to-back samples
    exp4 = '{0, 0, 0, 0, 4, 8, 12, 0, 0};
    exp8 = '{0, 0, 0, 0, 0, 8, 16, 24, 0};
    en_s = 1; en_d = 1;
    for (int n = 1; n <= 3; n++) begin
      fill(n, n);
      drive_mac();
      tick();
    end
    en_s = 0; en_d = 0;
    for (int c = 3; c <= 8; c++) begin
      tick();
      chk("b2b_valid4", v4, exp4[c] != 0);
      chk("b2b_valid8", v8, exp8[c] != 0);
      if (exp4[c] != 0) chk("b2b_out4", $signed(out4), exp4[c]);
      if (exp8[c] != 0) chk("b2b_out8", $signed(out8), exp8[c]);
    end
    m_out4 = 12;
    m_out8 = 24;
    check_status();

    // Clear coincident with a fresh positive clamp: flag stays, count restarts at 1
    fill(30000, 2000);
    run_one(1);

    // Clear alone
    clr4 = 1; clr8 = 1;
    tick();
    clr4 = 0; clr8 = 0;
    m_sp4 = 0; m_sn4 = 0; m_cnt4 = 0;
    m_sp8 = 0; m_sn8 = 0; m_cnt8 = 0;
    check_status();

    // Randomised samples against the reference model
    for (int n = 0; n < 30; n++) begin
      randomize_channels();
      run_one($urandom_range(0, 7) == 0);
    end

    // Reset asserted while a sample is two stages in
    randomize_channels();
    drive_mac();
    en_s = 1; en_d = 1;
    tick();
    en_s = 0; en_d = 0;
    tick();
    tick();
    rst_n = 0;
    #1;
    m_out4 = 0; m_out8 = 0;
    m_sp4 = 0; m_sn4 = 0; m_sp8 = 0; m_sn8 = 0;
    m_cnt4 = 0; m_cnt8 = 0;
    chk("midrst_valid4", v4, 1'b0);
    chk("midrst_valid8", v8, 1'b0);
    check_status();
    tick();
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("postrst_valid4", v4, 1'b0);
      chk("postrst_valid8", v8, 1'b0);
    end
    check_status();

    // Pipeline is live again after release
    randomize_channels();
    run_one(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
